vga_timing_rx: RTL and testbench
================================

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixel ticks per line.
REQ-002 SHALL have parameter H_SYNC_START, default 656, hcount value at the first tick of hsync low.
REQ-003 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have parameter V_SYNC_START, default 490, vcount value of the first line after vsync falls.
REQ-006 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-007 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
REQ-008 SHALL have port clk, input, 1 bit, the single system clock (rising edge); reset is asynchronous and active-low.
REQ-009 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port pix_en, input, 1 bit, pixel tick strobe, one clk wide.
REQ-011 SHALL have port hsync_in, input, 1 bit, incoming horizontal sync, active-low, asynchronous to clk.
REQ-012 SHALL have port vsync_in, input, 1 bit, incoming vertical sync, active-low, asynchronous to clk.
REQ-013 SHALL have port hcount, output, 10 bits, recovered pixel column.
REQ-014 SHALL have port vcount, output, 10 bits, recovered line number.
REQ-015 SHALL have port blank, output, 1 bit, high outside the active area or when not locked.
REQ-016 SHALL have port locked, output, 1 bit, timing verified.
REQ-017 SHALL have port frame_start, output, 1 bit, one-clk pulse when vcount wraps to 0.
REQ-018 SHALL have port timing_err, output, 1 bit, one-clk pulse on any detected violation.

Function
REQ-019 SHALL pass hsync_in and vsync_in through two-flop synchronizers before any use; falling edges SHALL be detected on synchronized values, sampled only on pix_en ticks.
REQ-020 On a pix_en tick with an hsync falling edge, hcount SHALL load H_SYNC_START; on other pix_en ticks it SHALL increment, wrapping H_TOTAL-1 -> 0; it SHALL hold when pix_en=0.
REQ-021 On an hsync edge, vcount SHALL load V_SYNC_START if a vsync falling edge was flagged since the previous hsync edge, otherwise increment, wrapping V_TOTAL-1 -> 0; the flag SHALL clear on that hsync edge.
REQ-022 Line check: on an hsync edge in TRACK or LOCKED, hcount != H_SYNC_START-1 SHALL be a violation.
REQ-023 Frame check: the hsync edges between consecutive vsync flags, counted by a saturating 10-bit counter, != V_TOTAL SHALL be a violation.
REQ-024 Timeout: 1023 pix_en ticks without an hsync edge SHALL be a violation in any state.
REQ-025 FSM states SHALL be SEARCH, TRACK, LOCKED.
REQ-026 SEARCH -> TRACK on the first vsync flag; the good-frame counter SHALL clear.
REQ-027 TRACK: each violation-free frame SHALL increment the good-frame counter; on reaching LOCK_FRAMES the FSM SHALL go to LOCKED.
REQ-028 TRACK or LOCKED: any violation SHALL pulse timing_err for one clk, go to SEARCH, and drop locked in the same cycle.
REQ-029 A line violation and a timeout coinciding SHALL produce a single timing_err pulse.
REQ-030 locked SHALL be 1 only in LOCKED.
REQ-031 blank SHALL be 0 only when locked=1, hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-032 frame_start SHALL pulse only when locked=1.
REQ-033 All outputs SHALL be registered, with hcount/vcount updating in the clk after the qualifying pix_en tick.

Reset
REQ-034 rst_n=0 SHALL immediately force hcount=0, vcount=0, blank=1, locked=0, frame_start=0, timing_err=0, FSM=SEARCH, synchronizers to 1 (idle), and all counters and flags to 0.
REQ-035 Reset deassertion mid-frame SHALL restart in SEARCH with no timing_err pulse until after the first vsync flag.

Verification
REQ-036 Feed ideal 800x525 VGA timing (pix_en every 2nd clk) -> locked=1 after 2 full frames following the first vsync edge; timing_err never pulses.
REQ-037 After lock, shorten one line to 799 ticks -> one timing_err pulse at that hsync edge, locked=0 and blank=1 in the same cycle, relock after 2 further good frames.
REQ-038 After lock, send a 524-line frame -> timing_err pulse at the vsync flag, FSM in SEARCH.
REQ-039 Hold hsync_in high for 1100 ticks -> timing_err pulse at tick 1023, then no further pulse while in SEARCH.
REQ-040 Locked stream -> hcount 639->640 makes blank=1; vcount 524->0 produces one frame_start pulse; hsync edge loads hcount=656.
REQ-041 Assert rst_n=0 mid-line while locked -> all outputs at reset values without waiting for clk.

Source files
------------

// File: rtl/vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_rx
// Brief    : Recovers pixel/line position from incoming VGA syncs and locks
//            once the timing has been verified over consecutive frames.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_rx #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_ACTIVE     = 640,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_ACTIVE     = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       blank,
  output logic       locked,
  output logic       frame_start,
  output logic       timing_err
);

  localparam int              c_gw        = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam logic [9:0]      c_h_last    = 10'(H_TOTAL - 1);
  localparam logic [9:0]      c_h_sync    = 10'(H_SYNC_START);
  localparam logic [9:0]      c_h_pre     = 10'(H_SYNC_START - 1);
  localparam logic [9:0]      c_h_act     = 10'(H_ACTIVE);
  localparam logic [9:0]      c_v_last    = 10'(V_TOTAL - 1);
  localparam logic [9:0]      c_v_sync    = 10'(V_SYNC_START);
  localparam logic [9:0]      c_v_tot     = 10'(V_TOTAL);
  localparam logic [9:0]      c_v_act     = 10'(V_ACTIVE);
  localparam logic [9:0]      c_cnt_max   = 10'h3FF;
  localparam logic [9:0]      c_tmo_pre   = 10'd1022;
  localparam logic [c_gw-1:0] c_good_last = c_gw'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_hs_meta, r_hs_sync, r_hs_prev;
  logic            r_vs_meta, r_vs_sync, r_vs_prev;
  logic            r_vflag;
  logic [9:0]      r_hcount, r_vcount, r_lines, r_quiet;
  logic [c_gw-1:0] r_good, w_good_nxt;
  logic            r_blank, r_locked, r_frame_start, r_timing_err;
  logic [9:0]      w_hc_nxt, w_vc_nxt;
  logic            w_hs_fall, w_vs_fall, w_vload, w_vwrap;
  logic            w_line_err, w_tmo, w_frame_err, w_viol, w_err, w_lock_nxt;

  // Edges are judged only between consecutive pixel ticks, never raw clk samples.
  assign w_hs_fall   = pix_en & r_hs_prev & ~r_hs_sync;
  assign w_vs_fall   = pix_en & r_vs_prev & ~r_vs_sync;
  assign w_vload     = r_vflag | w_vs_fall;
  assign w_vwrap     = w_hs_fall & ~w_vload & (r_vcount == c_v_last);
  assign w_line_err  = w_hs_fall & (r_hcount != c_h_pre);
  assign w_tmo       = pix_en & ~w_hs_fall & (r_quiet == c_tmo_pre);
  assign w_frame_err = w_vs_fall & (r_lines != c_v_tot);
  assign w_viol      = w_line_err | w_tmo | w_frame_err;
  assign w_lock_nxt  = (w_state_nxt == LOCKED);

  always_comb begin
    w_hc_nxt = r_hcount;
    if (pix_en) begin
      if (w_hs_fall)                 w_hc_nxt = c_h_sync;
      else if (r_hcount == c_h_last) w_hc_nxt = '0;
      else                           w_hc_nxt = r_hcount + 10'd1;
    end
  end

  always_comb begin
    w_vc_nxt = r_vcount;
    if (w_hs_fall) begin
      if (w_vload)      w_vc_nxt = c_v_sync;
      else if (w_vwrap) w_vc_nxt = '0;
      else              w_vc_nxt = r_vcount + 10'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err       = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt = TRACK;
          w_good_nxt  = '0;
        end
      end
      TRACK: begin
        if (w_viol) begin
          w_err       = 1'b1;
          w_state_nxt = SEARCH;
        end else if (w_vs_fall) begin
          w_good_nxt = r_good + c_gw'(1);
          if (r_good == c_good_last) w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_viol) begin
          w_err       = 1'b1;
          w_state_nxt = SEARCH;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_meta <= 1'b1;
      r_hs_sync <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs_meta <= hsync_in;
      r_hs_sync <= r_hs_meta;
      r_vs_meta <= vsync_in;
      r_vs_sync <= r_vs_meta;
      if (pix_en) begin
        r_hs_prev <= r_hs_sync;
        r_vs_prev <= r_vs_sync;
      end
    end
  end

  // Line and quiet-time counters saturate so a dead input cannot wrap into a false pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_vflag  <= 1'b0;
      r_lines  <= '0;
      r_quiet  <= '0;
      r_good   <= '0;
      r_state  <= SEARCH;
    end else begin
      r_hcount <= w_hc_nxt;
      r_vcount <= w_vc_nxt;
      r_good   <= w_good_nxt;
      r_state  <= w_state_nxt;
      if (w_hs_fall)      r_vflag <= 1'b0;
      else if (w_vs_fall) r_vflag <= 1'b1;
      if (w_vs_fall)                             r_lines <= {9'd0, w_hs_fall};
      else if (w_hs_fall && r_lines != c_cnt_max) r_lines <= r_lines + 10'd1;
      if (pix_en) begin
        if (w_hs_fall)               r_quiet <= '0;
        else if (r_quiet != c_cnt_max) r_quiet <= r_quiet + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank       <= 1'b1;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_timing_err  <= 1'b0;
    end else begin
      r_blank       <= ~(w_lock_nxt & (w_hc_nxt < c_h_act) & (w_vc_nxt < c_v_act));
      r_locked      <= w_lock_nxt;
      r_frame_start <= w_vwrap & w_lock_nxt;
      r_timing_err  <= w_err;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign blank       = r_blank;
  assign locked      = r_locked;
  assign frame_start = r_frame_start;
  assign timing_err  = r_timing_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_rx
// Brief    : Self-checking bench for vga_timing_rx on a scaled-down raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_rx;

  localparam int HT    = 40;
  localparam int HSS   = 33;
  localparam int HA    = 32;
  localparam int VT    = 12;
  localparam int VSS   = 10;
  localparam int VA    = 8;
  localparam int LF    = 2;
  localparam int HSW   = 4;
  localparam int VSW   = 2;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n, pix_en, hsync_in, vsync_in;
  logic [9:0] hcount, vcount;
  logic       blank, locked, frame_start, timing_err;

  vga_timing_rx #(
    .H_TOTAL      (HT),
    .H_SYNC_START (HSS),
    .H_ACTIVE     (HA),
    .V_TOTAL      (VT),
    .V_SYNC_START (VSS),
    .V_ACTIVE     (VA),
    .LOCK_FRAMES  (LF)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .hcount      (hcount),
    .vcount      (vcount),
    .blank       (blank),
    .locked      (locked),
    .frame_start (frame_start),
    .timing_err  (timing_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Raster generator position and fault injections
  int g_h, g_v, g_tick;
  bit g_short, g_vskip, g_hold;
  // Reference model: expected receiver view, one tick behind the raw inputs
  int       m_h, m_v, m_lines, m_quiet, m_frames;
  bit       m_vpend;
  bit [1:0] m_hs_d, m_vs_d;
  // Observation tallies for scenario-level checks
  int o_err, o_fs, o_last_hf, o_err_tick;
  bit o_err_vf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_lines = 0; m_quiet = 0; m_frames = 0;
    m_vpend = 1'b0; m_hs_d = 2'b11; m_vs_d = 2'b11;
  endtask

  task automatic tick(input bit run_model, input bit release_rst);
    bit hs, vs, hf, vf, line_bad, tmo, frame_bad, viol, vload, wrap, lk;
    hs = g_hold || !(g_h >= HSS && g_h < HSS + HSW);
    vs = g_hold || !(g_v >= VSS && g_v < VSS + VSW);
    @(negedge clk);
    hsync_in = hs;
    vsync_in = vs;
    pix_en   = 1'b1;
    if (release_rst) begin
      rst_n = 1'b1;
      model_reset();
    end
    @(negedge clk);
    pix_en = 1'b0;
    if (run_model) begin
      hf        = m_hs_d[1] && !m_hs_d[0];
      vf        = m_vs_d[1] && !m_vs_d[0];
      line_bad  = hf && (m_h != HSS - 1);
      tmo       = !hf && (m_quiet == 1022);
      frame_bad = vf && (m_lines != VT);
      viol      = (m_frames >= 1) && (line_bad || tmo || frame_bad);
      vload     = m_vpend || vf;
      wrap      = hf && !vload && (m_v == VT - 1);
      m_h       = hf ? HSS : (m_h + 1) % HT;
      if (hf) begin
        m_v     = vload ? VSS : (m_v + 1) % VT;
        m_vpend = 1'b0;
      end else if (vf) begin
        m_vpend = 1'b1;
      end
      m_quiet = hf ? 0 : ((m_quiet < 1023) ? m_quiet + 1 : 1023);
      if (vf)                        m_lines = hf ? 1 : 0;
      else if (hf && m_lines < 1023) m_lines = m_lines + 1;
      if (viol)                      m_frames = 0;
      else if (vf && m_frames <= LF) m_frames = m_frames + 1;
      lk     = (m_frames > LF);
      m_hs_d = {m_hs_d[0], hs};
      m_vs_d = {m_vs_d[0], vs};

      chk("hcount", 32'(hcount), 32'(m_h));
      chk("vcount", 32'(vcount), 32'(m_v));
      chk("locked", 32'(locked), 32'(lk));
      chk("blank", 32'(blank), 32'(!(lk && m_h < HA && m_v < VA)));
      chk("frame_start", 32'(frame_start), 32'(wrap && lk));
      chk("timing_err", 32'(timing_err), 32'(viol));
      if (hf) o_last_hf = g_tick;
      if (timing_err) begin
        o_err++;
        o_err_tick = g_tick;
        o_err_vf   = vf;
        chk("err_drops_lock_and_blanks", 32'({locked, blank}), 32'd1);
      end
      if (frame_start) o_fs++;
    end
    if (g_short && g_h == HSS - 2) begin
      g_h     = HSS;
      g_short = 1'b0;
    end else if (g_h == HT - 1) begin
      g_h = 0;
      if (g_vskip && g_v == 4) begin
        g_v     = 6;
        g_vskip = 1'b0;
      end else begin
        g_v = (g_v + 1) % VT;
      end
    end else begin
      g_h = g_h + 1;
    end
    g_tick++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hcount"}, 32'(hcount), 32'd0);
    chk({tag, "_vcount"}, 32'(vcount), 32'd0);
    chk({tag, "_blank"}, 32'(blank), 32'd1);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_timing_err"}, 32'(timing_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    g_short = 1'b0; g_vskip = 1'b0; g_hold = 1'b0; g_tick = 0;
    o_err = 0; o_fs = 0; o_last_hf = 0; o_err_tick = 0; o_err_vf = 1'b0;
    model_reset();
    g_h = int'($urandom_range(0, HT - 1));
    g_v = int'($urandom_range(0, VT - 1));

    // Reset held while the raster runs from a random position
    repeat (int'($urandom_range(3, 60))) tick(1'b0, 1'b0);
    chk_reset_outputs("reset");

    // Ideal stream: acquire lock with no errors
    tick(1'b1, 1'b1);
    repeat (5 * FRAME + int'($urandom_range(0, FRAME))) tick(1'b1, 1'b0);
    chk("ideal_locked", 32'(locked), 32'd1);
    chk("ideal_no_err", 32'(o_err), 32'd0);

    // One frame_start per frame while locked
    o_fs = 0;
    repeat (2 * FRAME) tick(1'b1, 1'b0);
    chk("frame_start_count", 32'(o_fs), 32'd2);

    // One line a tick short: single error, then relock
    o_err = 0;
    g_short = 1'b1;
    repeat (5 * FRAME) tick(1'b1, 1'b0);
    chk("short_line_err_count", 32'(o_err), 32'd1);
    chk("short_line_relock", 32'(locked), 32'd1);

    // Frame one line short: error lands on the vsync flag
    o_err = 0; o_err_vf = 1'b0;
    g_vskip = 1'b1;
    repeat (5 * FRAME) tick(1'b1, 1'b0);
    chk("short_frame_err_count", 32'(o_err), 32'd1);
    chk("short_frame_err_at_vsync", 32'(o_err_vf), 32'd1);
    chk("short_frame_relock", 32'(locked), 32'd1);

    // Syncs stuck high for 1100 ticks: exactly one timeout pulse
    o_err = 0;
    g_hold = 1'b1;
    repeat (1100) tick(1'b1, 1'b0);
    chk("timeout_err_count", 32'(o_err), 32'd1);
    chk("timeout_latency", 32'(o_err_tick - o_last_hf), 32'd1023);
    g_hold = 1'b0;
    repeat (6 * FRAME + int'($urandom_range(0, HT))) tick(1'b1, 1'b0);
    chk("timeout_relock", 32'(locked), 32'd1);

    // Asynchronous reset mid-line while locked
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    repeat (3) tick(1'b0, 1'b0);
    o_err = 0;
    tick(1'b1, 1'b1);
    repeat (5 * FRAME) tick(1'b1, 1'b0);
    chk("post_reset_relock", 32'(locked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
